// File: rtl/fft8_input_reorder.sv
// Input stage of the 8-point DIT FFT: collects natural-order samples into bit-reversed
// ping-pong banks and issues the four stage-1 butterfly pairs from a full bank.
module fft8_input_reorder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_din_valid,
  input  logic [31:0] i_din,
  output logic        o_din_ready,
  input  logic        i_bfly_busy,
  output logic [31:0] o_data1,
  output logic [31:0] o_data2,
  output logic [31:0] o_w,
  output logic        o_enable_1,
  output logic        o_enable_2,
  output logic [1:0]  o_pair_idx,
  output logic        o_frame_done
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mem [2][8];
  logic [1:0]  r_full;
  logic [1:0]  w_full_nxt;
  logic        r_wr_bank;
  logic [2:0]  r_wr_cnt;
  logic        r_rd_bank;
  logic        w_rd_bank_nxt;
  logic [1:0]  r_pair_idx;
  logic [1:0]  w_idx_nxt;
  logic        w_load;
  logic        w_release;
  logic [31:0] r_data1, r_data2, r_w;
  logic        r_enable, r_frame_done;
  logic [31:0] w_data1_nxt, w_data2_nxt, w_w_nxt;
  logic        w_enable_nxt, w_frame_done_nxt;
  logic        w_accept;
  logic        w_wr_last;
  logic [2:0]  w_wr_addr;

  assign w_accept  = i_din_valid & ~r_full[r_wr_bank];
  assign w_wr_last = w_accept & (r_wr_cnt == 3'd7);
  assign w_wr_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2]};

  // Sample storage needs no reset: a bank is only read once its full flag is set.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_accept) begin
      r_mem[r_wr_bank][w_wr_addr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_wr_cnt     <= 3'd0;
      r_rd_bank    <= 1'b0;
      r_pair_idx   <= 2'd0;
      r_data1      <= 32'd0;
      r_data2      <= 32'd0;
      r_w          <= 32'd0;
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_full       <= w_full_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_pair_idx   <= w_idx_nxt;
      r_data1      <= w_data1_nxt;
      r_data2      <= w_data2_nxt;
      r_w          <= w_w_nxt;
      r_enable     <= w_enable_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 3'd1;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_idx_nxt     = r_pair_idx;
    w_load        = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = 2'd0;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!i_bfly_busy) begin
          if (r_pair_idx != 2'd3) begin
            w_idx_nxt = r_pair_idx + 2'd1;
            w_load    = 1'b1;
          end else begin
            // Retiring pair 3 frees the bank; chain straight into the other bank if ready.
            w_release     = 1'b1;
            w_rd_bank_nxt = ~r_rd_bank;
            w_idx_nxt     = 2'd0;
            if (r_full[~r_rd_bank]) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_full_nxt = r_full;
    if (w_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  always_comb begin
    w_data1_nxt      = r_data1;
    w_data2_nxt      = r_data2;
    w_w_nxt          = r_w;
    w_enable_nxt     = r_enable;
    w_frame_done_nxt = r_frame_done;
    if (w_load) begin
      w_data1_nxt      = r_mem[w_rd_bank_nxt][{w_idx_nxt, 1'b0}];
      w_data2_nxt      = r_mem[w_rd_bank_nxt][{w_idx_nxt, 1'b1}];
      w_w_nxt          = 32'h0000_0100;
      w_enable_nxt     = 1'b1;
      w_frame_done_nxt = (w_idx_nxt == 2'd3);
    end else if (w_state_nxt == S_IDLE) begin
      w_data1_nxt      = 32'd0;
      w_data2_nxt      = 32'd0;
      w_w_nxt          = 32'd0;
      w_enable_nxt     = 1'b0;
      w_frame_done_nxt = 1'b0;
    end
  end

  assign o_din_ready  = ~r_full[r_wr_bank];
  assign o_data1      = r_data1;
  assign o_data2      = r_data2;
  assign o_w          = r_w;
  assign o_enable_1   = r_enable;
  assign o_enable_2   = r_enable;
  assign o_pair_idx   = r_pair_idx;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Scoreboard bench for fft8_input_reorder: the driver queues expected pairs per frame,
// a negedge monitor retires them as the DUT issues pairs.
module tb_fft8_input_reorder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_din_valid = 1'b0;
  logic [31:0] i_din = 32'd0;
  logic        o_din_ready;
  logic        i_bfly_busy = 1'b0;
  logic [31:0] o_data1, o_data2, o_w;
  logic        o_enable_1, o_enable_2;
  logic [1:0]  o_pair_idx;
  logic        o_frame_done;

  fft8_input_reorder dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_din_valid  (i_din_valid),
    .i_din        (i_din),
    .o_din_ready  (o_din_ready),
    .i_bfly_busy  (i_bfly_busy),
    .o_data1      (o_data1),
    .o_data2      (o_data2),
    .o_w          (o_w),
    .o_enable_1   (o_enable_1),
    .o_enable_2   (o_enable_2),
    .o_pair_idx   (o_pair_idx),
    .o_frame_done (o_frame_done)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  idx;
    logic        fd;
  } exp_t;

  // Sample indices feeding data1/data2 for pairs 0..3, worked out by hand.
  localparam int ORD1 [4] = '{0, 2, 1, 3};
  localparam int ORD2 [4] = '{4, 6, 5, 7};

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   a_done = 1'b0;
  bit   b_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      exp_t e;
      chk("enable_2_tracks_enable_1", 128'(o_enable_2), 128'(o_enable_1));
      if (!o_enable_1) begin
        chk("idle_outputs_zero", 128'({o_data1, o_data2, o_w, o_pair_idx, o_frame_done}), 128'(0));
      end else if (!i_bfly_busy) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pair: got pair_idx %0d data1 %h, required no pair", o_pair_idx, o_data1);
        end else begin
          e = q.pop_front();
          chk("pair_data1", 128'(o_data1), 128'(e.d1));
          chk("pair_data2", 128'(o_data2), 128'(e.d2));
          chk("pair_w", 128'(o_w), 128'(32'h0000_0100));
          chk("pair_idx", 128'(o_pair_idx), 128'(e.idx));
          chk("pair_frame_done", 128'(o_frame_done), 128'(e.fd));
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, output int waits);
    i_din       = d;
    i_din_valid = 1'b1;
    waits       = 0;
    forever begin
      @(negedge i_clk);
      if (o_din_ready) break;
      waits++;
      if (waits > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got din_ready 0 for %0d cycles, required 1", waits);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input bit gap,
                            output int waits_total);
    int   w;
    exp_t e;
    waits_total = 0;
    for (int n = 0; n < 8; n++) begin
      send(base + step * 32'(n), w);
      waits_total += w;
      if (n == 7) begin
        for (int k = 0; k < 4; k++) begin
          e.d1  = base + step * 32'(ORD1[k]);
          e.d2  = base + step * 32'(ORD2[k]);
          e.idx = 2'(k);
          e.fd  = (k == 3);
          q.push_back(e);
        end
      end
      if (gap) begin
        i_din_valid = 1'b0;
        @(posedge i_clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_enable_1) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_queue_empty", 128'(q.size()), 128'(0));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int wt2;

    // reset values
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    chk("rst_din_ready", 128'(o_din_ready), 128'(1'b1));
    chk("rst_data1", 128'(o_data1), 128'(0));
    chk("rst_data2", 128'(o_data2), 128'(0));
    chk("rst_w", 128'(o_w), 128'(0));
    chk("rst_enable_1", 128'(o_enable_1), 128'(1'b0));
    chk("rst_enable_2", 128'(o_enable_2), 128'(1'b0));
    chk("rst_pair_idx", 128'(o_pair_idx), 128'(0));
    chk("rst_frame_done", 128'(o_frame_done), 128'(1'b0));
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      chk("idle_enable", 128'(o_enable_1), 128'(1'b0));
      chk("idle_ready", 128'(o_din_ready), 128'(1'b1));
    end

    // real ramp n<<8: first pair exactly one edge after x7
    send_frame(32'h0000_0000, 32'h0000_0100, 1'b0, wt);
    i_din_valid = 1'b0;
    chk("lat_enable_at_E", 128'(o_enable_1), 128'(1'b0));
    @(posedge i_clk);
    #1;
    chk("lat_enable_at_E1", 128'(o_enable_1), 128'(1'b1));
    chk("lat_idx_at_E1", 128'(o_pair_idx), 128'(0));
    chk("lat_data2_at_E1", 128'(o_data2), 128'(32'h0000_0400));
    drain();

    // 16 continuous samples, imag = n
    send_frame(32'h0000_0000, 32'h0001_0000, 1'b0, wt);
    send_frame(32'h0008_0000, 32'h0001_0000, 1'b0, wt2);
    i_din_valid = 1'b0;
    chk("stream_no_ready_stall", 128'(wt + wt2), 128'(0));
    drain();

    // stall on pair 1 of frame A while B and C arrive
    fork
      begin
        send_frame(32'h0A00_0A00, 32'h0001_0001, 1'b0, wt);
        a_done = 1'b1;
        send_frame(32'h0B00_0B00, 32'h0001_0001, 1'b0, wt);
        b_done = 1'b1;
        send_frame(32'h0C0C_0000, 32'h0000_0001, 1'b0, wt);
        i_din_valid = 1'b0;
      end
      begin
        wait (a_done);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_bfly_busy = 1'b1;
        wait (b_done);
        chk("stall_ready_low", 128'(o_din_ready), 128'(1'b0));
        for (int i = 0; i < 4; i++) begin
          @(negedge i_clk);
          chk("stall_hold_idx", 128'(o_pair_idx), 128'(1));
          chk("stall_hold_data1", 128'(o_data1), 128'(32'h0A02_0A02));
          chk("stall_hold_enable", 128'(o_enable_1), 128'(1'b1));
        end
        @(posedge i_clk);
        #1;
        i_bfly_busy = 1'b0;
        @(posedge i_clk);
        #1;
        chk("release_idx2", 128'(o_pair_idx), 128'(2));
        chk("release_ready_still_low", 128'(o_din_ready), 128'(1'b0));
        @(posedge i_clk);
        #1;
        chk("release_idx3", 128'(o_pair_idx), 128'(3));
        chk("release_done3", 128'(o_frame_done), 128'(1'b1));
        chk("release_ready_before_free", 128'(o_din_ready), 128'(1'b0));
        @(posedge i_clk);
        #1;
        chk("nobubble_enable", 128'(o_enable_1), 128'(1'b1));
        chk("nobubble_idx0", 128'(o_pair_idx), 128'(0));
        chk("nobubble_b_x0", 128'(o_data1), 128'(32'h0B00_0B00));
        chk("ready_after_free", 128'(o_din_ready), 128'(1'b1));
        @(posedge i_clk);
        #1;
        chk("nobubble_idx1", 128'(o_pair_idx), 128'(1));
        chk("nobubble_b_x2", 128'(o_data1), 128'(32'h0B02_0B02));
      end
    join
    drain();

    // partial frame discarded by reset
    for (int n = 0; n < 5; n++) begin
      send(32'hDEAD_0000 + 32'(n), wt);
    end
    i_din_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    chk("midrst_ready", 128'(o_din_ready), 128'(1'b1));
    chk("midrst_enable", 128'(o_enable_1), 128'(1'b0));
    send_frame(32'h0C00_C000, 32'h0001_0010, 1'b0, wt);
    i_din_valid = 1'b0;
    drain();

    // valid toggling 1/0
    send_frame(32'h00F0_0F00, 32'h0011_0101, 1'b1, wt);
    i_din_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
